// File: rtl/pps_nco_tuner.sv
// rtl/pps_nco_tuner.sv - PPS-disciplined NCO tuning-word controller with lock detect
// Measures clk_hi cycles per PPS period and steers the NCO phase increment toward GPS time.
module pps_nco_tuner #(
    parameter int                CNT_W       = 28,
    parameter int                NOMINAL_CNT = 100_000_000,
    parameter int                MAX_DEV     = 1000,
    parameter int                TW_W        = 32,
    parameter logic [TW_W-1:0]   TW_INIT     = TW_W'(922441722),
    parameter logic [TW_W-1:0]   TW_MIN      = '0,
    parameter logic [TW_W-1:0]   TW_MAX      = {TW_W{1'b1}},
    parameter int                GAIN_SHIFT  = 4,
    parameter int                LOCK_TOL    = 2,
    parameter int                LOCK_COUNT  = 4
) (
    input  logic              clk_hi,
    input  logic              rst,
    input  logic              enable,
    input  logic              pps_in,
    output logic [TW_W-1:0]   tune_word,
    output logic              tune_valid,
    output logic [CNT_W-1:0]  err_out,
    output logic              locked
);

    localparam int EW   = TW_W + CNT_W + GAIN_SHIFT + 1;
    localparam int LC_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0]        TIMEOUT_C = CNT_W'(NOMINAL_CNT + MAX_DEV);
    localparam logic signed [CNT_W:0]   NOM_C     = (CNT_W+1)'(NOMINAL_CNT);
    localparam logic [CNT_W:0]          MAX_DEV_C = (CNT_W+1)'(MAX_DEV);
    localparam logic [CNT_W:0]          TOL_C     = (CNT_W+1)'(LOCK_TOL);
    localparam logic [LC_W-1:0]         LC_FULL   = LC_W'(LOCK_COUNT);
    localparam logic signed [EW-1:0]    TW_MIN_X  = $signed({{(EW-TW_W){1'b0}}, TW_MIN});
    localparam logic signed [EW-1:0]    TW_MAX_X  = $signed({{(EW-TW_W){1'b0}}, TW_MAX});

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEASURE,
        S_UPDATE
    } state_t;

    state_t             r_state;
    logic               r_s1;
    logic               r_s2;
    logic               r_s3;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_meas;
    logic [TW_W-1:0]    r_tune_word;
    logic               r_tune_valid;
    logic [CNT_W-1:0]   r_err_out;
    logic               r_locked;
    logic [LC_W-1:0]    r_lock_cnt;

    logic                   w_edge;
    logic signed [CNT_W:0]  w_err;
    logic signed [CNT_W:0]  w_neg_err;
    logic [CNT_W:0]         w_abs_err;
    logic                   w_reject;
    logic                   w_in_tol;
    logic signed [EW-1:0]   w_corr;
    logic signed [EW-1:0]   w_tw_ext;
    logic signed [EW-1:0]   w_diff;
    logic [TW_W-1:0]        w_tw_next;
    logic [LC_W-1:0]        w_lc_next;

    assign w_edge = r_s2 & ~r_s3;

    // One extra bit keeps the error signed even when meas is far below nominal.
    assign w_err     = $signed({1'b0, r_meas}) - NOM_C;
    assign w_neg_err = -w_err;
    assign w_abs_err = w_err[CNT_W] ? $unsigned(w_neg_err) : $unsigned(w_err);
    assign w_reject  = w_abs_err > MAX_DEV_C;
    assign w_in_tol  = w_abs_err <= TOL_C;

    assign w_corr    = $signed({{(EW-CNT_W-1){w_err[CNT_W]}}, w_err}) <<< GAIN_SHIFT;
    assign w_tw_ext  = $signed({{(EW-TW_W){1'b0}}, r_tune_word});
    assign w_diff    = w_tw_ext - w_corr;
    assign w_tw_next = (w_diff < TW_MIN_X) ? TW_MIN :
                       (w_diff > TW_MAX_X) ? TW_MAX : w_diff[TW_W-1:0];

    assign w_lc_next = !w_in_tol            ? '0 :
                       (r_lock_cnt == LC_FULL) ? r_lock_cnt : r_lock_cnt + LC_W'(1);

    always_ff @(posedge clk_hi or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= pps_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_ff @(posedge clk_hi or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_meas       <= '0;
            r_tune_word  <= TW_INIT;
            r_tune_valid <= 1'b0;
            r_err_out    <= '0;
            r_locked     <= 1'b0;
            r_lock_cnt   <= '0;
        end else begin
            r_tune_valid <= 1'b0;
            if (!enable) begin
                r_state    <= S_IDLE;
                r_cnt      <= '0;
                r_locked   <= 1'b0;
                r_lock_cnt <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_edge) begin
                            r_cnt   <= '0;
                            r_state <= S_MEASURE;
                        end
                    end
                    S_MEASURE: begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        // A coincident edge and timeout resolves in favour of the edge.
                        if (w_edge) begin
                            r_meas  <= r_cnt + CNT_W'(1);
                            r_cnt   <= '0;
                            r_state <= S_UPDATE;
                        end else if (r_cnt == TIMEOUT_C) begin
                            r_cnt      <= '0;
                            r_locked   <= 1'b0;
                            r_lock_cnt <= '0;
                            r_state    <= S_IDLE;
                        end
                    end
                    S_UPDATE: begin
                        r_cnt     <= r_cnt + CNT_W'(1);
                        r_err_out <= w_err[CNT_W-1:0];
                        r_state   <= S_MEASURE;
                        if (w_reject) begin
                            r_locked   <= 1'b0;
                            r_lock_cnt <= '0;
                        end else begin
                            r_tune_word  <= w_tw_next;
                            r_tune_valid <= 1'b1;
                            r_lock_cnt   <= w_lc_next;
                            r_locked     <= (w_lc_next == LC_FULL);
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign tune_word  = r_tune_word;
    assign tune_valid = r_tune_valid;
    assign err_out    = r_err_out;
    assign locked     = r_locked;

endmodule

// File: tb/tb_pps_nco_tuner.sv
// tb/tb_pps_nco_tuner.sv - self-checking bench for pps_nco_tuner with an event-level model
// Two instances differ only in TW_INIT so the low clamp can be exercised alongside normal tracking.
module tb_pps_nco_tuner;

    localparam int NOM  = 1000;
    localparam int MDEV = 50;

    logic        clk_hi = 1'b0;
    logic        rst;
    logic        enable;
    logic        pps_in;

    logic [31:0] tw_a, tw_b;
    logic        tv_a, tv_b;
    logic [11:0] err_a, err_b;
    logic        lk_a, lk_b;

    int checks   = 0;
    int failures = 0;
    int vcount   = 0;
    bit cmp_en   = 1'b0;

    pps_nco_tuner #(
        .CNT_W(12), .NOMINAL_CNT(NOM), .MAX_DEV(MDEV), .TW_W(32),
        .TW_INIT(32'd1000000), .GAIN_SHIFT(2), .LOCK_TOL(2), .LOCK_COUNT(4)
    ) u_dut_a (
        .clk_hi(clk_hi), .rst(rst), .enable(enable), .pps_in(pps_in),
        .tune_word(tw_a), .tune_valid(tv_a), .err_out(err_a), .locked(lk_a)
    );

    pps_nco_tuner #(
        .CNT_W(12), .NOMINAL_CNT(NOM), .MAX_DEV(MDEV), .TW_W(32),
        .TW_INIT(32'd20), .GAIN_SHIFT(2), .LOCK_TOL(2), .LOCK_COUNT(4)
    ) u_dut_b (
        .clk_hi(clk_hi), .rst(rst), .enable(enable), .pps_in(pps_in),
        .tune_word(tw_b), .tune_valid(tv_b), .err_out(err_b), .locked(lk_b)
    );

    always #5 clk_hi = ~clk_hi;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint clamp32(input longint v);
        if (v < 0) return 0;
        if (v > 64'd4294967295) return 64'd4294967295;
        return v;
    endfunction

    // Model: edges are timestamped when sampled, acted on two cycles later,
    // and a measured period's result lands one cycle after that.
    int     m_cyc;
    bit     m_prev;
    int     m_q[$];
    bit     m_edge;
    bit     m_meas_on;
    int     m_t0;
    bit     m_pend;
    int     m_pend_err;
    longint m_tw_a, m_tw_b;
    bit     m_valid;
    int     m_err;
    int     m_lc;
    bit     m_locked;

    always @(posedge clk_hi or posedge rst) begin
        if (rst) begin
            m_cyc = 0; m_prev = 0; m_q.delete(); m_meas_on = 0; m_pend = 0;
            m_tw_a = 1000000; m_tw_b = 20; m_valid = 0; m_err = 0; m_lc = 0; m_locked = 0;
        end else begin
            m_cyc++;
            m_valid = 0;
            m_edge  = 0;
            if (m_q.size() > 0 && m_q[0] + 2 == m_cyc) begin
                void'(m_q.pop_front());
                m_edge = 1;
            end
            if (pps_in && !m_prev) m_q.push_back(m_cyc);
            m_prev = pps_in;
            if (!enable) begin
                m_meas_on = 0; m_pend = 0; m_lc = 0; m_locked = 0;
            end else if (m_pend) begin
                m_pend = 0;
                m_err  = m_pend_err;
                if (m_err > MDEV || m_err < -MDEV) begin
                    m_lc = 0; m_locked = 0;
                end else begin
                    m_tw_a  = clamp32(m_tw_a - m_err * 4);
                    m_tw_b  = clamp32(m_tw_b - m_err * 4);
                    m_valid = 1;
                    if (m_err <= 2 && m_err >= -2) m_lc = (m_lc < 4) ? m_lc + 1 : 4;
                    else m_lc = 0;
                    m_locked = (m_lc == 4);
                end
            end else if (m_edge && m_meas_on) begin
                m_pend     = 1;
                m_pend_err = (m_cyc - m_t0) - NOM;
                m_t0       = m_cyc;
            end else if (m_edge) begin
                m_meas_on = 1;
                m_t0      = m_cyc;
            end else if (m_meas_on && m_cyc == m_t0 + NOM + MDEV + 1) begin
                m_meas_on = 0; m_lc = 0; m_locked = 0;
            end
        end
    end

    always @(negedge clk_hi) begin
        if (cmp_en) begin
            check("tune_word_a", longint'(tw_a), m_tw_a);
            check("tune_word_b", longint'(tw_b), m_tw_b);
            check("tune_valid_a", longint'(tv_a), longint'(m_valid));
            check("tune_valid_b", longint'(tv_b), longint'(m_valid));
            check("err_out_a", longint'($signed(err_a)), longint'(m_err));
            check("locked_a", longint'(lk_a), longint'(m_locked));
            check("locked_b", longint'(lk_b), longint'(m_locked));
            if (tv_a) vcount++;
        end
    end

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk_hi);
            #2;
        end
    endtask

    task automatic period(input int p, input int w = 4);
        pps_in = 1'b1;
        step(w);
        pps_in = 1'b0;
        step(p - w);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        rst = 1'b0; enable = 1'b1; pps_in = 1'b0;
        #1 rst = 1'b1;
        #2 cmp_en = 1'b1;
        step(3);
        check("reset_tune_word", longint'(tw_a), 1000000);
        check("reset_locked", longint'(lk_a), 0);
        check("reset_err_out", longint'(err_a), 0);
        rst = 1'b0;
        step(2);

        // nominal period: five accepted zero-error updates, lock on the fourth
        v = vcount;
        repeat (6) period(1000);
        check("t1_valid_pulses", longint'(vcount - v), 5);
        check("t1_tune_word", longint'(tw_a), 1000000);
        check("t1_locked", longint'(lk_a), 1);

        // slow period: tune word walks down by 40 per update
        do_reset();
        period(1010);
        period(1010);
        check("t2_tw_first", longint'(tw_a), 999960);
        check("t2_err", longint'($signed(err_a)), 10);
        period(1010);
        period(1010);
        check("t2_tw_third", longint'(tw_a), 999880);
        check("t2_locked", longint'(lk_a), 0);

        // lock then lose PPS: timeout drops lock, next edge only restarts
        do_reset();
        repeat (6) period(1000);
        check("t3_locked_before", longint'(lk_a), 1);
        step(100);
        check("t3_locked_after", longint'(lk_a), 0);
        check("t3_tw_held", longint'(tw_a), 1000000);
        v = vcount;
        period(1000);
        check("t3_no_valid", longint'(vcount - v), 0);

        // glitch edge: two rejected periods, then recovery
        do_reset();
        repeat (5) period(1000);
        period(300);
        check("t4_locked_pre", longint'(lk_a), 1);
        v = vcount;
        period(700);
        check("t4_err_glitch", longint'($signed(err_a)), -700);
        check("t4_unlocked", longint'(lk_a), 0);
        check("t4_no_valid1", longint'(vcount - v), 0);
        period(1000);
        check("t4_err_short", longint'($signed(err_a)), -300);
        check("t4_no_valid2", longint'(vcount - v), 0);
        period(1000);
        check("t4_recovered", longint'(vcount - v), 1);
        check("t4_err_zero", longint'($signed(err_a)), 0);

        // low clamp on the TW_INIT=20 instance
        do_reset();
        v = vcount;
        period(1040);
        period(1040);
        check("t5_tw_b_clamped", longint'(tw_b), 0);
        check("t5_tw_a", longint'(tw_a), 999840);
        check("t5_valid", longint'(vcount - v), 1);
        check("t5_err", longint'($signed(err_a)), 40);

        // reset in MEASURE, reset in UPDATE, then 2-cycle PPS pulses
        do_reset();
        repeat (3) period(1010);
        check("t6_tw_pre", longint'(tw_a), 999920);
        rst = 1'b1;
        step(1);
        check("t6_meas_rst_tw", longint'(tw_a), 1000000);
        check("t6_meas_rst_err", longint'(err_a), 0);
        rst = 1'b0;
        step(2);
        period(1010);
        v = vcount;
        pps_in = 1'b1;
        step(3);
        rst = 1'b1;
        pps_in = 1'b0;
        step(1);
        check("t6_upd_rst_tw", longint'(tw_a), 1000000);
        check("t6_upd_rst_err", longint'(err_a), 0);
        check("t6_upd_rst_valid", longint'(vcount - v), 0);
        rst = 1'b0;
        step(2);
        v = vcount;
        repeat (3) period(1000, 2);
        check("t6_narrow_pulses", longint'(vcount - v), 2);

        // enable low: tune word frozen, re-enable restarts measurement
        do_reset();
        period(1010);
        period(1010);
        enable = 1'b0;
        step(5);
        check("t7_tw_held", longint'(tw_a), 999960);
        v = vcount;
        repeat (2) period(1000);
        check("t7_no_valid", longint'(vcount - v), 0);
        enable = 1'b1;
        step(10);
        period(1000);
        check("t7_restart_only", longint'(vcount - v), 0);
        period(1000);
        check("t7_resumed", longint'(vcount - v), 1);
        check("t7_tw_final", longint'(tw_a), 999960);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
